// File: rtl/mux3_scan_ctrl_if.sv
// Bus bundle between the mux scan sequencer and its environment.
// Optional change-flag signals exist only when MUX3_SCAN_CHG_EN is defined.
interface mux3_scan_ctrl_if #(
  parameter int DWELL_W = 8
);
  logic               en;
  logic [2:0]         mask;
  logic [DWELL_W-1:0] dwell;
  logic               o;
  logic [1:0]         s;
  logic [2:0]         smp;
  logic               smp_vld;
  logic [1:0]         ch;
  logic               frame_done;
`ifdef MUX3_SCAN_CHG_EN
  logic               chg_clr;
  logic [2:0]         chg;

  modport master (
    input  en, mask, dwell, o, chg_clr,
    output s, smp, smp_vld, ch, frame_done, chg
  );
  modport slave (
    output en, mask, dwell, o, chg_clr,
    input  s, smp, smp_vld, ch, frame_done, chg
  );
`else
  modport master (
    input  en, mask, dwell, o,
    output s, smp, smp_vld, ch, frame_done
  );
  modport slave (
    output en, mask, dwell, o,
    input  s, smp, smp_vld, ch, frame_done
  );
`endif
endinterface

// File: rtl/mux3_scan_ctrl.sv
// Scan sequencer driving the select of a 3:1 mux, sampling its output per channel.
// Define MUX3_SCAN_CHG_EN to add the sticky per-channel change flags (chg/chg_clr).
module mux3_scan_ctrl #(
  parameter int DWELL_W = 8,
  parameter int SETTLE  = 1
) (
  input logic              clk,
  input logic              rst,
  mux3_scan_ctrl_if.master bus
);
  localparam int SCNT_W = (SETTLE > 1) ? $clog2(SETTLE) : 1;

  typedef enum logic [1:0] {ST_IDLE, ST_SETTLE, ST_DWELL} state_t;

  state_t             r_state, w_state_nxt;
  logic [2:0]         r_fmask, w_fmask_nxt;
  logic [1:0]         r_s, w_s_nxt;
  logic [2:0]         r_smp, w_smp_nxt;
  logic               r_vld, w_vld_nxt;
  logic [1:0]         r_ch, w_ch_nxt;
  logic               r_fd, w_fd_nxt;
  logic [SCNT_W-1:0]  r_scnt, w_scnt_nxt;
  logic [DWELL_W-1:0] r_dcnt, w_dcnt_nxt;
`ifdef MUX3_SCAN_CHG_EN
  logic [2:0]         r_chg, w_chg_nxt;
`endif

  function automatic logic [1:0] f_lowest(input logic [2:0] m);
    return m[0] ? 2'd0 : (m[1] ? 2'd1 : 2'd2);
  endfunction

  function automatic logic [1:0] f_highest(input logic [2:0] m);
    return m[2] ? 2'd2 : (m[1] ? 2'd1 : 2'd0);
  endfunction

  function automatic logic f_has_above(input logic [2:0] m, input logic [1:0] cur);
    return (cur == 2'd0) ? (m[2:1] != 2'b00) : ((cur == 2'd1) ? m[2] : 1'b0);
  endfunction

  function automatic logic [1:0] f_next_above(input logic [2:0] m, input logic [1:0] cur);
    return ((cur == 2'd0) && m[1]) ? 2'd1 : 2'd2;
  endfunction

  always_comb begin
    w_state_nxt = r_state;
    w_fmask_nxt = r_fmask;
    w_s_nxt     = r_s;
    w_smp_nxt   = r_smp;
    w_vld_nxt   = 1'b0;
    w_ch_nxt    = r_ch;
    w_fd_nxt    = 1'b0;
    w_scnt_nxt  = r_scnt;
    w_dcnt_nxt  = r_dcnt;
`ifdef MUX3_SCAN_CHG_EN
    w_chg_nxt   = bus.chg_clr ? 3'b000 : r_chg;
`endif
    case (r_state)
      ST_IDLE: begin
        if (bus.en && (bus.mask != 3'b000)) begin
          w_fmask_nxt = bus.mask;
          w_s_nxt     = f_lowest(bus.mask);
          w_scnt_nxt  = SCNT_W'(SETTLE - 1);
          w_state_nxt = ST_SETTLE;
        end
      end
      ST_SETTLE: begin
        if (r_scnt == '0) begin
          w_smp_nxt[r_s] = bus.o;
          w_ch_nxt       = r_s;
          w_vld_nxt      = 1'b1;
          w_fd_nxt       = (r_s == f_highest(r_fmask));
          // dwell of 0 behaves as 1: the counter's terminal value is reached immediately
          w_dcnt_nxt     = (bus.dwell == '0) ? '0 : bus.dwell - 1'b1;
          w_state_nxt    = ST_DWELL;
`ifdef MUX3_SCAN_CHG_EN
          if (bus.o != r_smp[r_s]) w_chg_nxt[r_s] = 1'b1;
`endif
        end else begin
          w_scnt_nxt = r_scnt - 1'b1;
        end
      end
      ST_DWELL: begin
        if (r_dcnt != '0) begin
          w_dcnt_nxt = r_dcnt - 1'b1;
        end else if (!bus.en) begin
          w_state_nxt = ST_IDLE;
        end else if (f_has_above(r_fmask, r_s)) begin
          w_s_nxt     = f_next_above(r_fmask, r_s);
          w_scnt_nxt  = SCNT_W'(SETTLE - 1);
          w_state_nxt = ST_SETTLE;
        end else if (bus.mask != 3'b000) begin
          w_fmask_nxt = bus.mask;
          w_s_nxt     = f_lowest(bus.mask);
          w_scnt_nxt  = SCNT_W'(SETTLE - 1);
          w_state_nxt = ST_SETTLE;
        end else begin
          w_state_nxt = ST_IDLE;
        end
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= ST_IDLE;
      r_fmask <= 3'b000;
      r_s     <= 2'd0;
      r_smp   <= 3'b000;
      r_vld   <= 1'b0;
      r_ch    <= 2'd0;
      r_fd    <= 1'b0;
      r_scnt  <= '0;
      r_dcnt  <= '0;
`ifdef MUX3_SCAN_CHG_EN
      r_chg   <= 3'b000;
`endif
    end else begin
      r_state <= w_state_nxt;
      r_fmask <= w_fmask_nxt;
      r_s     <= w_s_nxt;
      r_smp   <= w_smp_nxt;
      r_vld   <= w_vld_nxt;
      r_ch    <= w_ch_nxt;
      r_fd    <= w_fd_nxt;
      r_scnt  <= w_scnt_nxt;
      r_dcnt  <= w_dcnt_nxt;
`ifdef MUX3_SCAN_CHG_EN
      r_chg   <= w_chg_nxt;
`endif
    end
  end

  assign bus.s          = r_s;
  assign bus.smp        = r_smp;
  assign bus.smp_vld    = r_vld;
  assign bus.ch         = r_ch;
  assign bus.frame_done = r_fd;
`ifdef MUX3_SCAN_CHG_EN
  assign bus.chg        = r_chg;
`endif
endmodule

// File: tb/tb_mux3_scan_ctrl.sv
// Bench for mux3_scan_ctrl: vector table, directed corner sequences and random run
// against a channel-period reference model.
module tb_mux3_scan_ctrl;
  localparam int DWELL_W = 8;
  localparam int SETTLE  = 1;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [2:0] abc = 3'b000;
  int         checks = 0;
  int         failures = 0;

  always #5 clk = ~clk;

  mux3_scan_ctrl_if #(.DWELL_W(DWELL_W)) bus();

  mux3_scan_ctrl #(.DWELL_W(DWELL_W), .SETTLE(SETTLE)) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  // the mux being scanned: a, b, c on selects 0, 1, 2
  assign bus.o = (bus.s == 2'd0) ? abc[0] : ((bus.s == 2'd1) ? abc[1] : abc[2]);

  // reference model: channel number plus position inside its period
  bit         m_active = 1'b0;
  int         m_chn = 0;
  int         m_pos = 0;
  int         m_len = 0;
  logic [2:0] m_fmask = 3'b000;
  logic [1:0] m_s = 2'd0;
  logic [2:0] m_smp = 3'b000;
  logic       m_vld = 1'b0;
  logic [1:0] m_ch = 2'd0;
  logic       m_fd = 1'b0;
`ifdef MUX3_SCAN_CHG_EN
  logic [2:0] m_chg = 3'b000;
`endif

  function automatic int f_low(input logic [2:0] m);
    for (int k = 0; k < 3; k++) if (m[k]) return k;
    return -1;
  endfunction

  function automatic int f_high(input logic [2:0] m);
    for (int k = 2; k >= 0; k--) if (m[k]) return k;
    return -1;
  endfunction

  function automatic int f_above(input logic [2:0] m, input int c);
    for (int k = c + 1; k < 3; k++) if (m[k]) return k;
    return -1;
  endfunction

  task automatic model_step();
    logic sv;
    if (rst) begin
      m_active = 1'b0; m_pos = 0; m_s = 2'd0; m_smp = 3'b000;
      m_vld = 1'b0; m_ch = 2'd0; m_fd = 1'b0;
`ifdef MUX3_SCAN_CHG_EN
      m_chg = 3'b000;
`endif
    end else begin
`ifdef MUX3_SCAN_CHG_EN
      if (bus.chg_clr) m_chg = 3'b000;
`endif
      m_vld = 1'b0;
      m_fd  = 1'b0;
      if (!m_active) begin
        if (bus.en && bus.mask != 3'b000) begin
          m_active = 1'b1; m_fmask = bus.mask; m_chn = f_low(bus.mask);
          m_pos = 0; m_s = 2'(m_chn);
        end
      end else if (m_pos == SETTLE - 1) begin
        sv = abc[m_chn];
`ifdef MUX3_SCAN_CHG_EN
        if (sv != m_smp[m_chn]) m_chg[m_chn] = 1'b1;
`endif
        m_smp[m_chn] = sv;
        m_ch  = 2'(m_chn);
        m_vld = 1'b1;
        m_fd  = (m_chn == f_high(m_fmask));
        m_len = SETTLE + ((bus.dwell == '0) ? 1 : int'(bus.dwell));
        m_pos++;
      end else if (m_pos == m_len - 1) begin
        if (!bus.en) m_active = 1'b0;
        else if (f_above(m_fmask, m_chn) >= 0) begin
          m_chn = f_above(m_fmask, m_chn); m_pos = 0; m_s = 2'(m_chn);
        end else if (bus.mask != 3'b000) begin
          m_fmask = bus.mask; m_chn = f_low(bus.mask); m_pos = 0; m_s = 2'(m_chn);
        end else m_active = 1'b0;
      end else begin
        m_pos++;
      end
    end
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h t=%0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] dut_vec();
    return 32'({bus.s, bus.smp, bus.smp_vld, bus.ch, bus.frame_done});
  endfunction

  task automatic tick();
    @(posedge clk);
    model_step();
    #1;
    chk("model", dut_vec(), 32'({m_s, m_smp, m_vld, m_ch, m_fd}));
`ifdef MUX3_SCAN_CHG_EN
    chk("model_chg", 32'(bus.chg), 32'(m_chg));
`endif
  endtask

  typedef struct packed {
    logic       rst;
    logic       en;
    logic [2:0] mask;
    logic [7:0] dwell;
    logic [2:0] abc;
    logic [1:0] s;
    logic [2:0] smp;
    logic       vld;
    logic [1:0] ch;
    logic       fd;
  } vec_t;

  vec_t tbl [13];

  initial begin
    int n1, n2, nv;
    bus.en = 1'b1; bus.mask = 3'b111; bus.dwell = 8'd2;
`ifdef MUX3_SCAN_CHG_EN
    bus.chg_clr = 1'b0;
`endif
    //           rst   en    mask    dwell  {c,b,a}   s     smp     vld   ch    fd
    tbl[0]  = '{1'b1, 1'b1, 3'b111, 8'd2, 3'b101, 2'd0, 3'b000, 1'b0, 2'd0, 1'b0};
    tbl[1]  = '{1'b1, 1'b1, 3'b111, 8'd2, 3'b101, 2'd0, 3'b000, 1'b0, 2'd0, 1'b0};
    tbl[2]  = '{1'b0, 1'b1, 3'b111, 8'd2, 3'b101, 2'd0, 3'b000, 1'b0, 2'd0, 1'b0};
    tbl[3]  = '{1'b0, 1'b1, 3'b111, 8'd2, 3'b101, 2'd0, 3'b001, 1'b1, 2'd0, 1'b0};
    tbl[4]  = '{1'b0, 1'b1, 3'b111, 8'd2, 3'b101, 2'd0, 3'b001, 1'b0, 2'd0, 1'b0};
    tbl[5]  = '{1'b0, 1'b1, 3'b111, 8'd2, 3'b101, 2'd1, 3'b001, 1'b0, 2'd0, 1'b0};
    tbl[6]  = '{1'b0, 1'b1, 3'b111, 8'd2, 3'b101, 2'd1, 3'b001, 1'b1, 2'd1, 1'b0};
    tbl[7]  = '{1'b0, 1'b1, 3'b111, 8'd2, 3'b101, 2'd1, 3'b001, 1'b0, 2'd1, 1'b0};
    tbl[8]  = '{1'b0, 1'b1, 3'b111, 8'd2, 3'b101, 2'd2, 3'b001, 1'b0, 2'd1, 1'b0};
    tbl[9]  = '{1'b0, 1'b1, 3'b111, 8'd2, 3'b101, 2'd2, 3'b101, 1'b1, 2'd2, 1'b1};
    tbl[10] = '{1'b0, 1'b1, 3'b111, 8'd2, 3'b101, 2'd2, 3'b101, 1'b0, 2'd2, 1'b0};
    tbl[11] = '{1'b0, 1'b1, 3'b111, 8'd2, 3'b101, 2'd0, 3'b101, 1'b0, 2'd2, 1'b0};
    tbl[12] = '{1'b0, 1'b1, 3'b111, 8'd2, 3'b101, 2'd0, 3'b101, 1'b1, 2'd0, 1'b0};

    for (int i = 0; i < 13; i++) begin
      rst = tbl[i].rst; bus.en = tbl[i].en; bus.mask = tbl[i].mask;
      bus.dwell = tbl[i].dwell; abc = tbl[i].abc;
      tick();
      chk($sformatf("tbl%0d", i), dut_vec(),
          32'({tbl[i].s, tbl[i].smp, tbl[i].vld, tbl[i].ch, tbl[i].fd}));
    end

    // two-channel mask with zero dwell: s alternates 0/2 every two cycles
    rst = 1'b1; tick(); rst = 1'b0;
    bus.mask = 3'b101; bus.dwell = 8'd0; bus.en = 1'b1;
    for (int k = 1; k <= 16; k++) begin
      abc = 3'($urandom_range(0, 7));
      tick();
      chk("seq3_s", 32'(bus.s), (((k - 1) / 2) % 2 == 1) ? 32'd2 : 32'd0);
      chk("seq3_fd", 32'(bus.frame_done), 32'(bus.smp_vld && bus.ch == 2'd2));
    end

    // mask shrinks during channel-0 dwell; current frame still covers 1 and 2
    rst = 1'b1; tick(); rst = 1'b0;
    bus.mask = 3'b111; bus.dwell = 8'd2; bus.en = 1'b1;
    tick(); tick();
    bus.mask = 3'b010;
    n1 = 0; n2 = 0;
    for (int k = 3; k <= 9; k++) begin
      tick();
      if (bus.smp_vld && bus.ch == 2'd1) n1++;
      if (bus.smp_vld && bus.ch == 2'd2) n2++;
    end
    chk("seq4_ch1_sampled", 32'(n1), 32'd1);
    chk("seq4_ch2_sampled", 32'(n2), 32'd1);
    nv = 0;
    for (int k = 10; k <= 21; k++) begin
      tick();
      chk("seq4_s", 32'(bus.s), 32'd1);
      chk("seq4_fd", 32'(bus.frame_done), 32'(bus.smp_vld));
      if (bus.smp_vld) nv++;
    end
    chk("seq4_pulses", 32'(nv), 32'd4);

    // en dropped in channel-1 settle: channel 1 still sampled, then silence
    rst = 1'b1; tick(); rst = 1'b0;
    bus.mask = 3'b111; bus.dwell = 8'd2; bus.en = 1'b1;
    tick(); tick(); tick(); tick();
    bus.en = 1'b0;
    tick();
    chk("seq5_vld", 32'({bus.smp_vld, bus.ch}), 32'({1'b1, 2'd1}));
    for (int k = 0; k < 22; k++) begin
      tick();
      chk("seq5_quiet", 32'({bus.smp_vld, bus.frame_done, bus.s}), 32'({1'b0, 1'b0, 2'd1}));
    end

    // reset right before a scheduled sample suppresses the pulse
    rst = 1'b1; tick(); rst = 1'b0;
    bus.mask = 3'b111; bus.dwell = 8'd1; bus.en = 1'b1; abc = 3'b111;
    tick();
    rst = 1'b1;
    tick();
    chk("seq6_rst", 32'({bus.smp_vld, bus.smp, bus.s}), 32'({1'b0, 3'b000, 2'd0}));
    rst = 1'b0;

`ifdef MUX3_SCAN_CHG_EN
    rst = 1'b1; tick(); rst = 1'b0;
    abc = 3'b000; bus.mask = 3'b010; bus.dwell = 8'd1; bus.en = 1'b1;
    tick(); tick();
    chk("chg_none", 32'(bus.chg), 32'(3'b000));
    tick();
    abc = 3'b010;
    tick();
    chk("chg_set", 32'(bus.chg), 32'(3'b010));
    bus.chg_clr = 1'b1;
    tick();
    chk("chg_clr", 32'(bus.chg), 32'(3'b000));
    abc = 3'b000;
    tick();
    chk("chg_set_wins", 32'(bus.chg), 32'(3'b010));
    bus.chg_clr = 1'b0;
`endif

    // random run against the model
    rst = 1'b1; tick(); rst = 1'b0;
    for (int k = 0; k < 1500; k++) begin
      rst       = ($urandom_range(0, 99) == 0);
      bus.en    = ($urandom_range(0, 15) != 0);
      if ($urandom_range(0, 7) == 0) bus.mask = 3'($urandom_range(0, 7));
      bus.dwell = 8'($urandom_range(0, 3));
      abc       = 3'($urandom_range(0, 7));
`ifdef MUX3_SCAN_CHG_EN
      bus.chg_clr = ($urandom_range(0, 9) == 0);
`endif
      tick();
      chk("rnd_s_legal", 32'(bus.s == 2'd3), 32'd0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/mux3_scan_ctrl.md
Name: mux3_scan_ctrl

Overview:
- Sequencer that sits directly upstream of the 3:1 single-bit mux and drives its 2-bit select `s`.
- Scans the enabled mux inputs (0 = a, 1 = b, 2 = c) in ascending order with a programmable dwell.
- Samples the mux output `o` once per channel into a per-channel result register.
- Reports each sample and each completed frame with one-cycle pulses to downstream logic.

Parameters:
- DWELL_W, 8: width of the `dwell` input and the dwell counter.
- SETTLE, 1: cycles between a select change and the sample point; legal range ≥1.

Ports:
- clk, input, 1: clock; all state updates on its rising edge.
- rst, input, 1: synchronous, active-high reset.
- en, input, 1: scan enable.
- mask, input, 3: channel enable; bit i enables channel i.
- dwell, input, DWELL_W: hold cycles after the sample; 0 is treated as 1.
- o, input, 1: mux output fed back for sampling.
- s, output, 2: select to the mux; never driven to 2'b11.
- smp, output, 3: last captured value per channel; bit i belongs to channel i.
- smp_vld, output, 1: one-cycle pulse when smp[ch] has just been updated.
- ch, output, 2: channel most recently sampled.
- frame_done, output, 1: one-cycle pulse on the last enabled channel's sample.

Behaviour:
- Reset values: s=00, smp=000, smp_vld=0, ch=00, frame_done=0, state=IDLE, all counters 0.
- States:
  - IDLE → SETTLE → DWELL → (SETTLE of next channel | IDLE).
- IDLE: when en=1 and mask≠000:
  - latch mask into fmask (frame mask);
  - s ← lowest set bit of fmask on the next edge;
  - enter SETTLE.
  - Otherwise stay in IDLE with s held.
- SETTLE: exactly SETTLE cycles.
  - On the edge ending the last SETTLE cycle: smp[s] ← o, ch ← s, smp_vld ← 1; enter DWELL.
- DWELL: exactly max(dwell,1) cycles.
  - smp_vld is high only in the first DWELL cycle.
  - dwell is sampled on entry to DWELL.
- Channel period = SETTLE + max(dwell,1) cycles; s is constant for the whole period.
- End of DWELL, in priority order:
  - en=0: go to IDLE; s holds its last value.
  - More enabled channels remain in fmask above the current one: s ← next higher set bit; enter SETTLE.
  - Otherwise (end of frame):
    - mask≠000: re-latch fmask ← mask; s ← lowest set bit; enter SETTLE.
    - mask=000: go to IDLE.
- frame_done is high in the same cycle as smp_vld when ch is the highest set bit of fmask.
- Single-channel mask (e.g. 010):
  - s stays at 01 continuously;
  - every sample asserts both smp_vld and frame_done.
- mask changes mid-frame are ignored until the frame boundary.
- en deassert mid-channel: the current channel finishes, including its sample and smp_vld, then IDLE.
- en re-assert in IDLE starts a new frame from the lowest set bit.
- rst at any state takes effect at the next edge, overrides everything, and suppresses any pending smp_vld.
- smp bits of unsampled or disabled channels keep their previous values.
- Dwell counter is DWELL_W bits wide and counts down with no wrap.

Optional Feature:
- Macro: MUX3_SCAN_CHG_EN.
- Defined:
  - adds input chg_clr (1) and output chg (3);
  - chg[i] is a sticky flag, set when a new sample of channel i differs from the prior smp[i];
  - chg_clr=1 clears all bits on the next edge;
  - a set event in the same cycle as chg_clr wins;
  - reset value of chg is 000.
- Undefined: chg and chg_clr ports are absent; all other behaviour is identical.

Test Plan:
1. rst=1 for 2 cycles with en=1, mask=111 → s=00, smp=000, smp_vld=0, ch=00, frame_done=0; rst low → s=00 one cycle later.
2. SETTLE=1, dwell=2, mask=111, a=1, b=0, c=1 → s runs 00×3, 01×3, 10×3 and repeats; smp_vld every 3 cycles with ch=0,1,2; after the first frame smp=101; frame_done only with ch=2.
3. mask=101, dwell=0 → s alternates 00, 10 every 2 cycles; s never 01 or 11; frame_done on each ch=2 sample.
4. mask 111→010 during the channel-0 dwell → channels 1 and 2 still sampled this frame; following frames keep s=01, with smp_vld and frame_done every period.
5. en dropped during the channel-1 SETTLE → channel-1 sample and smp_vld still occur, then IDLE; s stays 01; no further pulses over 20 cycles.
6. rst pulsed in the cycle before a scheduled sample → no smp_vld; smp=000, s=00 on the next cycle. With MUX3_SCAN_CHG_EN: b toggles between frames → chg=010; chg_clr → chg=000.
